// File: rtl/sipo_rx_if.sv
// Serial-in / parallel-out receiver bus.
// master drives serial bits and consumer controls; slave is the receiver.
interface sipo_rx_if #(
    parameter int N = 64
);
    logic         sin;
    logic         sin_en;
    logic         start;
    logic         out_ready;
    logic         ovf_clr;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         busy;
    logic         ovf;

    modport master (
        output sin, sin_en, start, out_ready, ovf_clr,
        input  out_data, out_valid, busy, ovf
    );

    modport slave (
        input  sin, sin_en, start, out_ready, ovf_clr,
        output out_data, out_valid, busy, ovf
    );
endinterface

// File: rtl/sipo_rx.sv
// MSB-first serial receiver with a one-word output slot.
// Words completing while the slot is still full are dropped and flagged.
module sipo_rx #(
    parameter int N = 64
) (
    input  logic      clk,
    input  logic      rst,
    sipo_rx_if.slave  bus
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         r_state;
    state_t         w_state_n;
    logic [N-1:0]   r_sh;
    logic [N-1:0]   w_sh_n;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_n;
    logic [N-1:0]   w_first;
    logic [N-1:0]   w_word;
    logic           w_done;
    logic           w_load;
    logic           w_drop;
    logic [N-1:0]   r_data;
    logic           r_valid;
    logic           r_ovf;
    logic           w_unused_msb;

    assign w_first = {{(N-1){1'b0}}, bus.sin};
    assign w_word  = {r_sh[N-2:0], bus.sin};

    // The top shift bit falls off on completion and is never read.
    assign w_unused_msb = r_sh[N-1];

    // Frame state, shift register and bit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_sh    <= w_sh_n;
            r_cnt   <= w_cnt_n;
        end
    end

    // Next-state: start (re)opens a frame, the Nth accepted bit closes it.
    always_comb begin
        w_state_n = r_state;
        w_sh_n    = r_sh;
        w_cnt_n   = r_cnt;
        w_done    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.sin_en && bus.start) begin
                    w_sh_n    = w_first;
                    w_cnt_n   = CW'(1);
                    w_state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.sin_en) begin
                    if (bus.start) begin
                        w_sh_n  = w_first;
                        w_cnt_n = CW'(1);
                    end else begin
                        w_sh_n = w_word;
                        if (r_cnt == CW'(N - 1)) begin
                            w_done    = 1'b1;
                            w_cnt_n   = '0;
                            w_state_n = IDLE;
                        end else begin
                            w_cnt_n = r_cnt + CW'(1);
                        end
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    // A same-cycle acceptance frees the slot for the completing word.
    assign w_load = w_done && (!r_valid || bus.out_ready);
    assign w_drop = w_done && r_valid && !bus.out_ready;

    // Output slot and sticky overflow; a new drop beats ovf_clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else if (r_valid && bus.out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_data;
    assign bus.out_valid = r_valid;
    assign bus.busy      = (r_state == SHIFT);
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: N=8 vector table plus hand sequences,
// and an N=64 frame.
module tb_sipo_rx;
    logic clk;
    logic rst;

    sipo_rx_if #(.N(8))  if8 ();
    sipo_rx_if #(.N(64)) if64 ();

    sipo_rx #(.N(8))  u8  (.clk(clk), .rst(rst), .bus(if8.slave));
    sipo_rx #(.N(64)) u64 (.clk(clk), .rst(rst), .bus(if64.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       en;
        logic       st;
        logic       sin;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [7:0] ed;
        logic       eb;
        logic       eo;
    } vec_t;

    vec_t tbl[$];
    int   checks;
    int   errors;
    int   rises;
    logic pv8;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push_row(input logic en, st, sin, rdy, clr, ev,
                            input logic [7:0] ed, input logic eb, eo);
        vec_t v;
        v.en = en; v.st = st; v.sin = sin; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ed = ed; v.eb = eb; v.eo = eo;
        tbl.push_back(v);
    endtask

    // Eight bits MSB first; rdy/clr only on the last bit.
    task automatic push_frame(input logic [7:0] w, input logic rdy, clr,
                              input logic pv, input logic [7:0] pd,
                              input logic po, qv, input logic [7:0] qd,
                              input logic qo);
        for (int i = 7; i >= 0; i--) begin
            if (i > 0)
                push_row(1'b1, (i == 7), w[i], 1'b0, 1'b0,
                         pv, pd, 1'b1, po);
            else
                push_row(1'b1, 1'b0, w[0], rdy, clr, qv, qd, 1'b0, qo);
        end
    endtask

    task automatic drive8(input logic en, st, sin, rdy, clr);
        if8.sin_en = en; if8.start = st; if8.sin = sin;
        if8.out_ready = rdy; if8.ovf_clr = clr;
    endtask

    task automatic cyc8();
        @(negedge clk);
        if (if8.out_valid && !pv8) rises++;
        pv8 = if8.out_valid;
    endtask

    task automatic send8(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            drive8(1'b1, (i == 0), w[7-i], 1'b0, 1'b0);
            cyc8();
        end
    endtask

    logic [7:0]  b2;
    logic [63:0] pat;

    initial begin
        checks = 0; errors = 0; rises = 0; pv8 = 1'b0;
        b2  = 8'hB2;
        pat = 64'hDEADBEEF_0123ABCD;
        rst = 1'b0;
        drive8(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if64.sin_en = 1'b0; if64.start = 1'b0; if64.sin = 1'b0;
        if64.out_ready = 1'b0; if64.ovf_clr = 1'b0;

        push_frame(8'hB2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0,
                   1'b1, 8'hB2, 1'b0);
        push_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b0,
                   1'b1, 8'hB2, 1'b1);
        push_row(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b0);
        push_frame(8'h5A, 1'b1, 1'b0, 1'b1, 8'hB2, 1'b0,
                   1'b1, 8'h5A, 1'b0);
        push_row(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);
        push_row(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);
        push_frame(8'h3C, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0,
                   1'b1, 8'h3C, 1'b0);
        push_frame(8'hC3, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0,
                   1'b1, 8'h3C, 1'b1);
        push_row(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        push_row(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
        push_row(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst8_data", 64'(if8.out_data), 64'h0);
        chk("rst8_flags", {if8.out_valid, if8.busy, if8.ovf}, 3'b000);
        chk("rst64_data", if64.out_data, 64'h0);
        chk("rst64_flags", {if64.out_valid, if64.busy, if64.ovf}, 3'b000);
        rst = 1'b1;

        // Vector table; first edge after release already samples.
        for (int i = 0; i < tbl.size(); i++) begin
            drive8(tbl[i].en, tbl[i].st, tbl[i].sin,
                   tbl[i].rdy, tbl[i].clr);
            cyc8();
            chk($sformatf("row%0d_valid", i), 64'(if8.out_valid),
                64'(tbl[i].ev));
            chk($sformatf("row%0d_data", i), 64'(if8.out_data),
                64'(tbl[i].ed));
            chk($sformatf("row%0d_busy", i), 64'(if8.busy),
                64'(tbl[i].eb));
            chk($sformatf("row%0d_ovf", i), 64'(if8.ovf),
                64'(tbl[i].eo));
        end

        // Gapped frame: 3 idle cycles after bit 4.
        send8(b2, 4);
        for (int g = 0; g < 3; g++) begin
            drive8(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            cyc8();
            chk($sformatf("gap%0d_busy", g), 64'(if8.busy), 64'h1);
        end
        for (int i = 4; i < 7; i++) begin
            drive8(1'b1, 1'b0, b2[7-i], 1'b0, 1'b0);
            cyc8();
        end
        chk("gap_valid_before_last", 64'(if8.out_valid), 64'h0);
        drive8(1'b1, 1'b0, b2[0], 1'b0, 1'b0);
        cyc8();
        chk("gap_valid", 64'(if8.out_valid), 64'h1);
        chk("gap_data", 64'(if8.out_data), 64'hB2);
        chk("gap_busy", 64'(if8.busy), 64'h0);
        drive8(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc8();
        chk("gap_accept", 64'(if8.out_valid), 64'h0);

        // Restart after 5 bits, then full frame 8'hFF.
        rises = 0;
        send8(8'hA8, 5);
        chk("rs_busy", 64'(if8.busy), 64'h1);
        chk("rs_no_valid", 64'(if8.out_valid), 64'h0);
        send8(8'hFF, 8);
        drive8(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc8();
        chk("rs_data", 64'(if8.out_data), 64'hFF);
        chk("rs_valid", 64'(if8.out_valid), 64'h1);
        chk("rs_rises", 64'(rises), 64'h1);
        chk("rs_ovf", 64'(if8.ovf), 64'h0);

        // Reset mid-frame with 8'hFF still pending.
        send8(8'h80, 4);
        drive8(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("mr_data", 64'(if8.out_data), 64'h0);
        chk("mr_flags", {if8.out_valid, if8.busy, if8.ovf}, 3'b000);
        cyc8();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive8(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            cyc8();
        end
        chk("mr_wait_busy", 64'(if8.busy), 64'h0);
        chk("mr_wait_valid", 64'(if8.out_valid), 64'h0);
        send8(8'h01, 8);
        chk("mr_data_01", 64'(if8.out_data), 64'h01);
        chk("mr_valid_01", 64'(if8.out_valid), 64'h1);
        drive8(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // N=64 basic frame.
        for (int i = 63; i >= 0; i--) begin
            if64.sin_en = 1'b1;
            if64.start  = (i == 63);
            if64.sin    = pat[i];
            @(negedge clk);
            if (i == 1) begin
                chk("n64_busy_mid", 64'(if64.busy), 64'h1);
                chk("n64_valid_mid", 64'(if64.out_valid), 64'h0);
            end
        end
        if64.sin_en = 1'b0; if64.start = 1'b0;
        chk("n64_data", if64.out_data, 64'hDEADBEEF_0123ABCD);
        chk("n64_valid", 64'(if64.out_valid), 64'h1);
        chk("n64_busy", 64'(if64.busy), 64'h0);
        chk("n64_ovf", 64'(if64.ovf), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter N, default 64: word width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low; asserting it (low) clears all state at once.
REQ-004 sin  input  1  serial data bit, MSB of the word first.
REQ-005 sin_en  input  1  bit qualifier: the bit on sin is taken only in a cycle where sin_en=1.
REQ-006 start  input  1  frame marker: when sampled with sin_en=1, the bit on sin in that cycle is word bit N-1.
REQ-007 out_ready  input  1  consumer accepts out_data in any cycle where out_valid=1 and out_ready=1.
REQ-008 ovf_clr  input  1  synchronous clear for the ovf flag.
REQ-009 out_data  output  N  assembled word, bit N-1 = first bit received.
REQ-010 out_valid  output  1  out_data holds a word that has not yet been accepted.
REQ-011 busy  output  1  high while a frame is being shifted in (state SHIFT).
REQ-012 ovf  output  1  sticky flag: a completed word was dropped.

Function
REQ-013 The block SHALL have two states: IDLE and SHIFT.
REQ-014 It SHALL keep an N-bit shift register sh and a bit counter cnt of width clog2(N)+1.
- IDLE, start=1 and sin_en=1 -> set sh = {0..0, sin}, set cnt = 1, go to SHIFT.
- IDLE, any other input -> no change; sin is ignored.
REQ-015 SHIFT, sin_en=1, start=0 -> set sh = {sh[N-2:0], sin} and increment cnt.
REQ-016 SHIFT, sin_en=0 -> hold sh, cnt and state; gaps of any length are allowed inside a frame.
REQ-017 SHIFT, start=1 and sin_en=1 (restart) -> discard the partial word and restart as in REQ-014; no flag is raised.
REQ-018 Completion is the cycle in which the Nth bit is accepted.
- The word {sh[N-2:0], sin} SHALL be presented on out_data from the next cycle.
- The state SHALL return to IDLE and cnt SHALL be set to 0.
REQ-019 Latency SHALL be exactly 1 cycle: out_valid rises on the edge that follows the sampling of the last bit.
REQ-020 Output slot: one holding register, out_data/out_valid.
- out_data SHALL change only when a word is loaded into the slot.
- out_valid SHALL be set when a word is loaded.
- out_valid SHALL be cleared when the word is accepted (out_valid=1 and out_ready=1) and no new word arrives in the same cycle.
REQ-021 Completion with the slot empty, or with an acceptance in the same cycle -> load the new word; out_valid stays or becomes 1; ovf is not set.
REQ-022 Completion with out_valid=1 and out_ready=0 -> drop the new word, keep out_data, set ovf=1.
REQ-023 ovf SHALL stay 1 until ovf_clr=1.
- If ovf_clr=1 in the same cycle as a new drop, ovf SHALL remain 1 (set wins).
REQ-024 out_ready=1 while out_valid=0 SHALL have no effect.
REQ-025 busy SHALL equal (state==SHIFT).
REQ-026 For N=2 the first bit SHALL occupy sh[0] and completion SHALL be on the second accepted bit.

Reset
REQ-027 While rst=0, all state SHALL be cleared asynchronously:
- state=IDLE, sh=0, cnt=0;
- out_data=0, out_valid=0, busy=0, ovf=0.
REQ-028 Reset asserted in the middle of a frame SHALL discard the partial word.
- After release the block SHALL wait for a new start.
REQ-029 The first rising clk edge after rst goes high SHALL already sample inputs normally.

Verification (all scenarios use N=8 unless stated)
REQ-030 Basic frame: start+sin_en with bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles, out_ready=0.
- Response: out_data=8'hB2 and out_valid=1 on the cycle after the 8th bit; busy=0.
REQ-031 Gapped frame: the same bits with sin_en=0 for 3 cycles after bit 4.
- Response: out_data=8'hB2, with completion 3 cycles later than in REQ-030.
REQ-032 Back-to-back frames 8'hB2 then 8'h5A, out_ready=0 throughout.
- Response: out_data stays 8'hB2 and ovf=1.
- Then ovf_clr=1 for one cycle -> ovf=0.
REQ-033 Simultaneous event: out_ready=1 in the completion cycle of 8'h5A while 8'hB2 is pending.
- Response: out_data=8'h5A, out_valid stays 1, ovf=0.
REQ-034 Restart: start after 5 bits, followed by a full frame 8'hFF.
- Response: out_data=8'hFF and exactly one out_valid rise.
REQ-035 Reset mid-frame: rst=0 after 4 bits, released, then frame 8'h01.
- Response: all outputs 0 during reset, then out_data=8'h01.
- Repeat REQ-030 with N=64 and pattern 64'hDEADBEEF_0123ABCD.
